// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des_pkg
// Description : Shared widths, DES PC1/shift tables, FSM encoding and the
//               28-bit half-key rotation helper for the DES key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

    localparam int KEY_W  = 64;
    localparam int CD_W   = 56;
    localparam int HALF_W = 28;
    localparam int RK_W   = 48;

    // Left-rotate amount that produces encrypt round key n from round key n-1
    localparam int SHIFT_SCHED [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2,
                                          1, 2, 2, 2, 2, 2, 2, 1};

    // PC1 source bit (1 = key MSB) for each C||D output bit 1..56
    localparam int PC1_TAB [1:56] = '{57, 49, 41, 33, 25, 17,  9,
                                       1, 58, 50, 42, 34, 26, 18,
                                      10,  2, 59, 51, 43, 35, 27,
                                      19, 11,  3, 60, 52, 44, 36,
                                      63, 55, 47, 39, 31, 23, 15,
                                       7, 62, 54, 46, 38, 30, 22,
                                      14,  6, 61, 53, 45, 37, 29,
                                      21, 13,  5, 28, 20, 12,  4};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    typedef logic [HALF_W-1:0] half_t;

    function automatic half_t rotate_half(input half_t x, input logic right, input logic two);
        half_t r;
        case ({right, two})
            2'b00:   r = {x[HALF_W-2:0], x[HALF_W-1]};
            2'b01:   r = {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
            2'b10:   r = {x[0], x[HALF_W-1:1]};
            default: r = {x[1:0], x[HALF_W-1:2]};
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_key_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : des_key_sched_if
// Description : Start/key request and round-key valid/ready stream bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface des_key_sched_if;
    import des_pkg::*;

    logic              start;
    logic [1:KEY_W]    key_64;
    logic              decrypt;
    logic              rk_ready;
    logic              rk_valid;
    logic [1:CD_W]     rk_56;
    logic [3:0]        round_idx;
    logic              busy;
    logic              done;

    modport master (
        output start, key_64, decrypt, rk_ready,
        input  rk_valid, rk_56, round_idx, busy, done
    );

    modport slave (
        input  start, key_64, decrypt, rk_ready,
        output rk_valid, rk_56, round_idx, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/des_pc1.sv
`default_nettype none
// ============================================================================
// Module      : des_pc1
// Description : DES Permuted Choice 1, 64-bit key to 56-bit C||D (pure wiring).
// Revision    : 1.0 - initial release
// ============================================================================
module des_pc1
    import des_pkg::*;
(
    input  logic [1:KEY_W] i_key_64,
    output logic [1:CD_W]  o_cd_56
);

    for (genvar i = 1; i <= CD_W; i++) begin : g_pc1
        assign o_cd_56[i] = i_key_64[PC1_TAB[i]];
    end

    // Parity bits never reach the schedule
    logic w_unused_parity;
    assign w_unused_parity = ^{i_key_64[8],  i_key_64[16], i_key_64[24], i_key_64[32],
                               i_key_64[40], i_key_64[48], i_key_64[56], i_key_64[64]};

endmodule
`default_nettype wire

// File: rtl/des_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : des_key_sched
// Description : Emits the 16 DES round keys (C||D, pre-PC2) for one key, one
//               per valid/ready handshake, in encrypt or decrypt order.
// Revision    : 1.0 - initial release
// ============================================================================
module des_key_sched
    import des_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    des_key_sched_if.slave bus
);

    state_t       r_state;
    state_t       w_state_nxt;
    half_t        r_c;
    half_t        r_d;
    logic         r_dir;
    logic [3:0]   r_idx;

    logic [1:CD_W] w_pc1;
    half_t         w_c0;
    half_t         w_d0;
    logic          w_hs;
    logic          w_last;
    logic          w_adv;
    logic          w_two;
    logic [15:0]   w_enc_two;
    logic [15:0]   w_dec_two;

    des_pc1 u_pc1 (
        .i_key_64 (bus.key_64),
        .o_cd_56  (w_pc1)
    );

    assign w_c0 = w_pc1[1:HALF_W];
    assign w_d0 = w_pc1[HALF_W+1:CD_W];

    // Per-current-index step size: encrypt walks the table forward from
    // entry 2, decrypt walks it backward from entry 16 (rotating right).
    for (genvar i = 0; i < 16; i++) begin : g_sched
        if (i < 15) begin : g_step
            assign w_enc_two[i] = (SHIFT_SCHED[i+2]  == 2);
            assign w_dec_two[i] = (SHIFT_SCHED[16-i] == 2);
        end else begin : g_end
            assign w_enc_two[i] = 1'b0;
            assign w_dec_two[i] = 1'b0;
        end
    end

    assign w_two  = r_dir ? w_dec_two[r_idx] : w_enc_two[r_idx];
    assign w_hs   = (r_state == ST_RUN) && bus.rk_ready;
    assign w_last = (r_idx == 4'd15);
    assign w_adv  = w_hs && !w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start)         w_state_nxt = ST_RUN;
            ST_RUN:  if (w_hs && w_last)    w_state_nxt = ST_FIN;
            ST_FIN:                         w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    // Decrypt starts from PC1 itself (the encrypt round-16 key) and unwinds
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c   <= '0;
            r_d   <= '0;
            r_dir <= 1'b0;
            r_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_c   <= bus.decrypt ? w_c0 : rotate_half(w_c0, 1'b0, 1'b0);
                        r_d   <= bus.decrypt ? w_d0 : rotate_half(w_d0, 1'b0, 1'b0);
                        r_dir <= bus.decrypt;
                        r_idx <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_adv) begin
                        r_c   <= rotate_half(r_c, r_dir, w_two);
                        r_d   <= rotate_half(r_d, r_dir, w_two);
                        r_idx <= r_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rk_valid  = (r_state == ST_RUN);
    assign bus.busy      = (r_state == ST_RUN);
    assign bus.done      = (r_state == ST_FIN);
    assign bus.rk_56     = {r_c, r_d};
    assign bus.round_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_key_sched
// Description : Self-checking bench for des_key_sched against a table-driven
//               DES key-schedule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_key_sched;

    logic clk = 1'b0;
    logic reset;

    des_key_sched_if bus ();

    des_key_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [55:0] exp_keys [16];
    logic [55:0] obs_keys [16];

    localparam int PC1_REF [56] = '{57, 49, 41, 33, 25, 17,  9,
                                     1, 58, 50, 42, 34, 26, 18,
                                    10,  2, 59, 51, 43, 35, 27,
                                    19, 11,  3, 60, 52, 44, 36,
                                    63, 55, 47, 39, 31, 23, 15,
                                     7, 62, 54, 46, 38, 30, 22,
                                    14,  6, 61, 53, 45, 37, 29,
                                    21, 13,  5, 28, 20, 12,  4};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        logic [55:0] t;
        t = {28'd0, x} << n;
        return t[27:0] | t[55:28];
    endfunction

    // Standard schedule: cumulative left rotations of PC1 halves; decrypt is the reverse list
    task automatic build_model(input logic [63:0] key, input logic dec);
        logic [55:0] p;
        logic [55:0] enc [16];
        logic [27:0] c;
        logic [27:0] d;
        for (int i = 0; i < 56; i++) p[55-i] = key[64-PC1_REF[i]];
        c = p[55:28];
        d = p[27:0];
        for (int r = 0; r < 16; r++) begin
            c = rotl28(c, SHIFTS[r]);
            d = rotl28(d, SHIFTS[r]);
            enc[r] = {c, d};
        end
        for (int r = 0; r < 16; r++) exp_keys[r] = dec ? enc[15-r] : enc[r];
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low for stall_n cycles
    task automatic run_sched(input logic [63:0] key, input logic dec, input int mode,
                             input int stall_n, input bit interfere, input int abort_at);
        int  hs;
        int  cyc;
        logic rdy;
        build_model(key, dec);
        bus.key_64  = key;
        bus.decrypt = dec;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        hs  = 0;
        cyc = 0;
        while (hs < 16 && cyc < 400) begin
            if (abort_at >= 0 && hs == abort_at) begin
                check("abort_point_idx", bus.round_idx, hs);
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                2:       rdy = (cyc >= stall_n);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.rk_ready = rdy;
            check("run_valid", bus.rk_valid, 1);
            check("run_idx",   bus.round_idx, hs);
            check("run_key",   bus.rk_56, exp_keys[hs]);
            check("run_busy",  bus.busy, 1);
            check("run_done",  bus.done, 0);
            obs_keys[hs] = bus.rk_56;
            if (interfere && hs == 7) begin
                bus.start   = 1'b1;
                bus.key_64  = ~key;
                bus.decrypt = ~dec;
            end
            tick();
            bus.start = 1'b0;
            if (rdy) hs++;
            cyc++;
        end
        if (hs < 16) check("handshake_timeout", hs, 16);
        check("fin_done",  bus.done, 1);
        check("fin_valid", bus.rk_valid, 0);
        check("fin_busy",  bus.busy, 0);
        if (interfere) bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("post_done",  bus.done, 0);
        check("post_valid", bus.rk_valid, 0);
        tick();
        check("idle_valid", bus.rk_valid, 0);
        check("idle_done",  bus.done, 0);
    endtask

    initial begin
        logic [63:0] k;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.key_64   = '0;
        bus.decrypt  = 1'b0;
        bus.rk_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", bus.rk_valid, 0);
        check("rst_key",   bus.rk_56, 0);
        check("rst_idx",   bus.round_idx, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        reset = 1'b0;
        tick();

        run_sched(64'h133457799BBCDFF1, 1'b0, 0, 0, 1'b0, -1);
        check("enc_vec_first", obs_keys[0],  56'hE19955FAACCF1E);
        check("enc_vec_last",  obs_keys[15], 56'hF0CCAAF556678F);

        run_sched(64'h133457799BBCDFF1, 1'b1, 0, 0, 1'b0, -1);
        check("dec_vec_first",  obs_keys[0],  56'hF0CCAAF556678F);
        check("dec_vec_second", obs_keys[1],  56'hF866557AAB33C7);
        check("dec_vec_last",   obs_keys[15], 56'hE19955FAACCF1E);

        run_sched(64'h133457799BBCDFF1, 1'b0, 2, 5, 1'b0, -1);

        for (int n = 0; n < 4; n++) begin
            k = {$urandom(), $urandom()};
            run_sched(k, 1'($urandom_range(0, 1)), 1, 0, 1'b0, -1);
        end

        run_sched(64'h0E329232EA6D0D73, 1'b0, 1, 0, 1'b1, -1);
        run_sched(64'h0E329232EA6D0D73, 1'b1, 1, 0, 1'b1, -1);

        k = {$urandom(), $urandom()};
        run_sched(k, 1'b0, 0, 0, 1'b0, 9);
        reset = 1'b1;
        tick();
        check("abort_valid", bus.rk_valid, 0);
        check("abort_key",   bus.rk_56, 0);
        check("abort_idx",   bus.round_idx, 0);
        check("abort_busy",  bus.busy, 0);
        check("abort_done",  bus.done, 0);
        reset = 1'b0;
        tick();
        check("abort_no_done", bus.done, 0);
        run_sched(k, 1'b1, 0, 0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
